// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants: 640x480@60 defaults, a tiny simulation set, sync polarities.
package vga_timing_pkg;

  localparam int unsigned POS_W     = 10;
  localparam int unsigned MAX_TOTAL = 1 << POS_W;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_BOTTOM  = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_TOP     = 33;

  // 10 x 6 raster so whole frames take only 60 clocks.
  localparam int unsigned SIM_H_DISPLAY = 4;
  localparam int unsigned SIM_H_FRONT   = 2;
  localparam int unsigned SIM_H_SYNC    = 2;
  localparam int unsigned SIM_H_BACK    = 2;
  localparam int unsigned SIM_V_DISPLAY = 2;
  localparam int unsigned SIM_V_BOTTOM  = 1;
  localparam int unsigned SIM_V_SYNC    = 1;
  localparam int unsigned SIM_V_TOP     = 2;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync/active decodes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned DISPLAY    = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter bit          SYNC_POL   = SYNC_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  output logic [POS_W-1:0] pos_o,
  output logic             sync_o,
  output logic             active_o,
  output logic             wrap_o
);

  localparam int unsigned      W       = POS_W + 1;
  localparam logic [POS_W-1:0] LAST    = POS_W'(TOTAL - 1);
  localparam logic [W-1:0]     SYNC_LO = W'(SYNC_START);
  localparam logic [W-1:0]     SYNC_HI = W'(SYNC_START + SYNC_LEN);
  localparam logic [W-1:0]     DISP_HI = W'(DISPLAY);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             sync_q, sync_d;
  logic             active_q, active_d;
  logic [W-1:0]     pos_ext;

  assign wrap_o = (pos_q == LAST);

  always_comb begin
    pos_d = pos_q;
    if (adv_i) begin
      pos_d = wrap_o ? '0 : pos_q + POS_W'(1);
    end
  end

  // Decode the next position so the flops line up with the position being presented.
  always_comb begin
    pos_ext  = {1'b0, pos_d};
    sync_d   = ((pos_ext >= SYNC_LO) && (pos_ext < SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
    active_d = (pos_ext < DISP_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= LAST;
      sync_q   <= ~SYNC_POL;
      active_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign pos_o    = pos_q;
  assign sync_o   = sync_q;
  assign active_o = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster timing generator: positions, syncs, visible flag, line/frame pulses
// and a frame counter that advances on entry into vertical blank.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_BOTTOM  = VGA_V_BOTTOM,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_TOP     = VGA_V_TOP,
  parameter bit          SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             display_on_o,
  output logic [POS_W-1:0] hpos_o,
  output logic [POS_W-1:0] vpos_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic [POS_W-1:0] frame_cnt_o
);

  localparam int unsigned      H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned      V_TOTAL  = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam logic [POS_W-1:0] LAST_VIS = POS_W'(V_DISPLAY - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic h_active, v_active, h_wrap, v_wrap, v_adv;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic [POS_W-1:0] frame_cnt_q, frame_cnt_d;

  assign v_adv = ce_i & h_wrap;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .DISPLAY    (H_DISPLAY),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv_i    (ce_i),
    .pos_o    (hpos_o),
    .sync_o   (hsync_o),
    .active_o (h_active),
    .wrap_o   (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .DISPLAY    (V_DISPLAY),
    .SYNC_START (V_DISPLAY + V_BOTTOM),
    .SYNC_LEN   (V_SYNC),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv_i    (v_adv),
    .pos_o    (vpos_o),
    .sync_o   (vsync_o),
    .active_o (v_active),
    .wrap_o   (v_wrap)
  );

  // Wrap flags on the current position tell us the next position is column 0 / origin.
  always_comb begin
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;
    if (ce_i) begin
      line_start_d  = h_wrap;
      frame_start_d = h_wrap & v_wrap;
      if (h_wrap && (vpos_o == LAST_VIS)) begin
        frame_cnt_d = frame_cnt_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign display_on_o  = h_active & v_active;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 640x480 instance and a tiny 10x6 active-high instance,
// both compared every cycle against a position/frame model built from the raster rules.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: default 640x480 timing.
  logic       a_rst_n = 1'b1;
  logic       a_ce = 1'b0;
  logic       a_hs, a_vs, a_disp, a_ls, a_fs;
  logic [9:0] a_hpos, a_vpos, a_fcnt;
  logic [34:0] a_obs;
  assign a_obs = {a_hpos, a_vpos, a_hs, a_vs, a_disp, a_ls, a_fs, a_fcnt};

  vga_timing_gen u_dut_a (
    .clk           (clk),
    .rst_n         (a_rst_n),
    .ce_i          (a_ce),
    .hsync_o       (a_hs),
    .vsync_o       (a_vs),
    .display_on_o  (a_disp),
    .hpos_o        (a_hpos),
    .vpos_o        (a_vpos),
    .line_start_o  (a_ls),
    .frame_start_o (a_fs),
    .frame_cnt_o   (a_fcnt)
  );

  // Instance B: 10x6 raster, active-high syncs.
  logic       b_rst_n = 1'b1;
  logic       b_ce = 1'b0;
  logic       b_hs, b_vs, b_disp, b_ls, b_fs;
  logic [9:0] b_hpos, b_vpos, b_fcnt;
  logic [34:0] b_obs;
  assign b_obs = {b_hpos, b_vpos, b_hs, b_vs, b_disp, b_ls, b_fs, b_fcnt};

  vga_timing_gen #(
    .H_DISPLAY (SIM_H_DISPLAY),
    .H_FRONT   (SIM_H_FRONT),
    .H_SYNC    (SIM_H_SYNC),
    .H_BACK    (SIM_H_BACK),
    .V_DISPLAY (SIM_V_DISPLAY),
    .V_BOTTOM  (SIM_V_BOTTOM),
    .V_SYNC    (SIM_V_SYNC),
    .V_TOP     (SIM_V_TOP),
    .SYNC_POL  (SYNC_ACTIVE_HIGH)
  ) u_dut_b (
    .clk           (clk),
    .rst_n         (b_rst_n),
    .ce_i          (b_ce),
    .hsync_o       (b_hs),
    .vsync_o       (b_vs),
    .display_on_o  (b_disp),
    .hpos_o        (b_hpos),
    .vpos_o        (b_vpos),
    .line_start_o  (b_ls),
    .frame_start_o (b_fs),
    .frame_cnt_o   (b_fcnt)
  );

  // Reference model state: presented position and frames entered into vertical blank.
  int ah = 799, av = 524, af = 0;
  int bh = 9,   bv = 5,   bf = 0;

  function automatic logic [34:0] model_vec(input int h, v, f, hd, hf, hs, vd, vb, vs,
                                            input bit pol);
    logic hsy, vsy;
    hsy = (h >= hd + hf && h < hd + hf + hs) ? pol : ~pol;
    vsy = (v >= vd + vb && v < vd + vb + vs) ? pol : ~pol;
    return {10'(h), 10'(v), hsy, vsy, (h < hd && v < vd), (h == 0), (h == 0 && v == 0),
            10'(f % 1024)};
  endfunction

  function automatic logic [34:0] a_exp();
    return model_vec(ah, av, af, 640, 16, 96, 480, 10, 2, 1'b0);
  endfunction

  function automatic logic [34:0] b_exp();
    return model_vec(bh, bv, bf, 4, 2, 2, 2, 1, 1, 1'b1);
  endfunction

  task automatic model_adv(inout int h, inout int v, inout int f, input int ht, vt, vd);
    h++;
    if (h == ht) begin
      h = 0;
      v++;
      if (v == vt) v = 0;
    end
    if (h == 0 && v == vd) f++;
  endtask

  // Called at a falling edge: drive ce, let one rising edge pass, advance the model.
  task automatic a_tick(input logic ce);
    a_ce = ce;
    @(negedge clk);
    if (ce) model_adv(ah, av, af, 800, 525, 480);
  endtask

  task automatic b_tick(input logic ce);
    b_ce = ce;
    @(negedge clk);
    if (ce) model_adv(bh, bv, bf, 10, 6, 2);
  endtask

  task automatic test_reset();
    logic [34:0] exp;
    #2;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    #1;
    n_cmp++; exp = a_exp();
    if (a_obs !== exp) begin
      n_err++; $display("FAIL reset_a: got %h expected %h", a_obs, exp);
    end
    n_cmp++; exp = b_exp();
    if (b_obs !== exp) begin
      n_err++; $display("FAIL reset_b: got %h expected %h", b_obs, exp);
    end
    @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    a_tick(1'b1);
    n_cmp++; exp = a_exp();
    if (a_obs !== exp || a_obs !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0}) begin
      n_err++; $display("FAIL first_edge: got %h expected %h", a_obs, exp);
    end
    a_tick(1'b1);
    n_cmp++; exp = a_exp();
    if (a_obs !== exp) begin
      n_err++; $display("FAIL second_edge: got %h expected %h", a_obs, exp);
    end
  endtask

  // One full line from hpos 1: hsync window, display_on fall, 799 -> 0 wrap with vpos 0 -> 1.
  task automatic test_line();
    logic [34:0] exp;
    for (int i = 0; i < 800; i++) begin
      a_tick(1'b1);
      n_cmp++; exp = a_exp();
      if (a_obs !== exp) begin
        n_err++; $display("FAIL line h=%0d v=%0d: got %h expected %h", ah, av, a_obs, exp);
      end
    end
  endtask

  task automatic test_ce_hold();
    logic [34:0] exp;
    int guard = 0;
    while (ah != 655 && guard < 2000) begin
      a_tick(1'b1);
      guard++;
    end
    n_cmp++; exp = a_exp();
    if (ah != 655 || a_obs !== exp) begin
      n_err++; $display("FAIL reach_655: got %h expected %h", a_obs, exp);
    end
    for (int i = 0; i < 5; i++) begin
      a_tick(1'b0);
      n_cmp++; exp = a_exp();
      if (a_obs !== exp) begin
        n_err++; $display("FAIL ce_hold %0d: got %h expected %h", i, a_obs, exp);
      end
    end
    a_tick(1'b1);
    n_cmp++; exp = a_exp();
    if (a_obs !== exp || a_hs !== 1'b0) begin
      n_err++; $display("FAIL ce_release: got %h expected %h", a_obs, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [34:0] exp;
    int guard = 0;
    while (!(ah == 300 && av == 3) && guard < 5000) begin
      a_tick(1'b1);
      n_cmp++; exp = a_exp();
      if (a_obs !== exp) begin
        n_err++; $display("FAIL run h=%0d v=%0d: got %h expected %h", ah, av, a_obs, exp);
      end
      guard++;
    end
    n_cmp++;
    if (ah != 300 || av != 3) begin
      n_err++; $display("FAIL reach_300_3: got guard %0d expected below 5000", guard);
    end
    #2;
    a_rst_n = 1'b0;
    #1;
    ah = 799; av = 524; af = 0;
    n_cmp++; exp = a_exp();
    if (a_obs !== exp) begin
      n_err++; $display("FAIL async_reset: got %h expected %h", a_obs, exp);
    end
    @(negedge clk);
    a_rst_n = 1'b1;
    a_tick(1'b1);
    n_cmp++; exp = a_exp();
    if (a_obs !== exp) begin
      n_err++; $display("FAIL async_release: got %h expected %h", a_obs, exp);
    end
    a_ce = 1'b0;
  endtask

  task automatic test_random_ce();
    logic [34:0] exp;
    for (int i = 0; i < 400; i++) begin
      b_tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      n_cmp++; exp = b_exp();
      if (b_obs !== exp) begin
        n_err++; $display("FAIL random_ce h=%0d v=%0d: got %h expected %h", bh, bv, b_obs, exp);
      end
    end
  endtask

  // 1024+ frames: frame_cnt must pass through 1023 -> 0 without extra or missed steps.
  task automatic test_frame_wrap();
    logic [34:0] exp;
    int wraps = 0;
    for (int i = 0; i < 1025 * 60; i++) begin
      b_tick(1'b1);
      if (bh == 0 && bv == 2 && (bf % 1024) == 0) wraps++;
      n_cmp++; exp = b_exp();
      if (b_obs !== exp) begin
        n_err++; $display("FAIL frame_wrap f=%0d h=%0d v=%0d: got %h expected %h",
                          bf, bh, bv, b_obs, exp);
      end
    end
    n_cmp++;
    if (wraps < 1) begin
      n_err++; $display("FAIL wrap_seen: got %0d wraps expected at least 1", wraps);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_ce_hold();
    test_async_reset();
    test_random_ce();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
